// File: rtl/led_pair_sequencer_pkg.sv
// rtl/led_pair_sequencer_pkg.sv - shared state, mode and width constants for the LED pair sequencer
package led_pair_sequencer_pkg;

    localparam int DIV_W_DEF = 24;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MD_ROTATE = 2'b00;
    localparam logic [1:0] MD_BOUNCE = 2'b01;
    localparam logic [1:0] MD_ONELAP = 2'b10;

endpackage

// File: rtl/led_pair_sequencer_tick_gen.sv
// rtl/led_pair_sequencer_tick_gen.sv - programmable rate divider producing one-cycle advance ticks
import led_pair_sequencer_pkg::*;

module seq_tick_gen #(
    parameter int               DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(5000000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = div_q - DIV_W'(1);

    // A freshly loaded divider or a clear restarts the period, so no tick in those cycles.
    assign tick = en & ~clr & ~div_ld & (cnt == last);

    // Divider register; a zero request is stored as 1 so the period is never empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_RST;
        end else if (div_ld) begin
            div_q <= (div_val == '0) ? DIV_W'(1) : div_val;
        end
    end

    // Prescaler counts 0..div-1 only while enabled and is held at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (div_ld || clr || !en || (cnt == last)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_pair_sequencer.sv
// rtl/led_pair_sequencer.sv - run/step sequencer driving the C/B/A select of the LED pair decoder
import led_pair_sequencer_pkg::*;

module led_pair_sequencer #(
    parameter int               DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(5000000)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             STEP,
    input  logic             DIR,
    input  logic [1:0]       MODE,
    input  logic             DIV_LD,
    input  logic [DIV_W-1:0] DIV_VAL,
    output logic             C,
    output logic             B,
    output logic             A,
    output logic             BUSY,
    output logic             LAP
);

    logic [0:0] state;
    logic [2:0] index;
    logic       dir_q;
    logic       lap_q;
    logic       start_q;
    logic       stop_q;
    logic       step_q;
    logic [1:0] mode_q;
    logic [2:0] lap_cnt;

    logic       start_req;
    logic       stop_req;
    logic       step_req;
    logic       mode_chg;
    logic       tick;

    logic       adv_dir;
    logic       turn;
    logic [2:0] nxt_idx;
    logic       nxt_dir;

    assign start_req = START & ~start_q;
    assign stop_req  = STOP & ~stop_q;
    assign step_req  = STEP & ~step_q;
    assign mode_chg  = (MODE != mode_q);

    assign {C, B, A} = index;
    assign BUSY      = (state == ST_RUN);
    assign LAP       = lap_q;

    seq_tick_gen #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_tick (
        .clk     (CLK),
        .rst     (RST),
        .en      (state == ST_RUN),
        .clr     (stop_req),
        .div_ld  (DIV_LD),
        .div_val (DIV_VAL),
        .tick    (tick)
    );

    // Next index/direction for one advance; a single step in IDLE takes its direction straight from DIR.
    always_comb begin
        adv_dir = (state == ST_RUN) ? dir_q : DIR;
        nxt_idx = adv_dir ? (index - 3'd1) : (index + 3'd1);
        nxt_dir = adv_dir;
        turn    = adv_dir ? (index == 3'd0) : (index == 3'd7);
        if ((MODE == MD_BOUNCE) && turn) begin
            nxt_idx = adv_dir ? 3'd1 : 3'd6;
            nxt_dir = ~adv_dir;
        end
    end

    // Button edge capture, run/idle control, index advance and lap pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            index   <= 3'd0;
            dir_q   <= 1'b0;
            lap_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            step_q  <= 1'b0;
            mode_q  <= MD_ROTATE;
            lap_cnt <= 3'd0;
        end else begin
            start_q <= START;
            stop_q  <= STOP;
            step_q  <= STEP;
            mode_q  <= MODE;
            lap_q   <= 1'b0;
            if (state == ST_IDLE) begin
                if (start_req && !stop_req) begin
                    state   <= ST_RUN;
                    dir_q   <= DIR;
                    lap_cnt <= 3'd0;
                end else if (step_req) begin
                    index <= nxt_idx;
                    dir_q <= nxt_dir;
                end
            end else begin
                if (stop_req) begin
                    state <= ST_IDLE;
                end else if (tick) begin
                    index <= nxt_idx;
                    dir_q <= nxt_dir;
                    if (MODE == MD_ONELAP) begin
                        // A mode switch restarts the lap count, with this advance as the first.
                        lap_cnt <= mode_chg ? 3'd1 : (lap_cnt + 3'd1);
                        if (!mode_chg && (lap_cnt == 3'd7)) begin
                            lap_q <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        lap_cnt <= 3'd0;
                        lap_q   <= turn;
                    end
                end else if (mode_chg) begin
                    lap_cnt <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pair_sequencer.sv
// tb/tb_led_pair_sequencer.sv - directed self-checking bench for led_pair_sequencer
module tb_led_pair_sequencer;

    localparam int DIV_W = 24;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             STOP;
    logic             STEP;
    logic             DIR;
    logic [1:0]       MODE;
    logic             DIV_LD;
    logic [DIV_W-1:0] DIV_VAL;
    logic             C;
    logic             B;
    logic             A;
    logic             BUSY;
    logic             LAP;

    int vectors = 0;
    int errors  = 0;

    led_pair_sequencer #(.DIV_W(DIV_W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .STOP    (STOP),
        .STEP    (STEP),
        .DIR     (DIR),
        .MODE    (MODE),
        .DIV_LD  (DIV_LD),
        .DIV_VAL (DIV_VAL),
        .C       (C),
        .B       (B),
        .A       (A),
        .BUSY    (BUSY),
        .LAP     (LAP)
    );

    always #5 CLK = ~CLK;

    task automatic clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic eb, input logic el, input logic [2:0] ei);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {BUSY, LAP, C, B, A};
        exp = {eb, el, ei};
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed busy/lap/cba=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load_div(input logic [DIV_W-1:0] v);
        DIV_LD  = 1'b1;
        DIV_VAL = v;
        clk(1);
        DIV_LD  = 1'b0;
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; STOP = 1'b0; STEP = 1'b0; DIR = 1'b0;
        MODE = 2'b00; DIV_LD = 1'b0; DIV_VAL = '0;
        clk(2);
        chk("reset", 1'b0, 1'b0, 3'd0);
        RST = 1'b0;
        clk(1);

        // rotate up, divider 4
        load_div(24'd4);
        START = 1'b1; clk(1); START = 1'b0;
        chk("rot_up_start", 1'b1, 1'b0, 3'd0);
        clk(3);
        chk("rot_up_pre1", 1'b1, 1'b0, 3'd0);
        clk(1);
        chk("rot_up_idx1", 1'b1, 1'b0, 3'd1);
        clk(4);
        chk("rot_up_idx2", 1'b1, 1'b0, 3'd2);
        clk(20);
        chk("rot_up_idx7", 1'b1, 1'b0, 3'd7);
        clk(4);
        chk("rot_up_wrap", 1'b1, 1'b1, 3'd0);
        clk(1);
        chk("rot_up_lap_off", 1'b1, 1'b0, 3'd0);
        STOP = 1'b1; clk(1); STOP = 1'b0;
        chk("rot_up_stop", 1'b0, 1'b0, 3'd0);

        // rotate down, divider 0 acts as 1
        load_div(24'd0);
        DIR = 1'b1;
        START = 1'b1; clk(1); START = 1'b0;
        chk("rot_dn_start", 1'b1, 1'b0, 3'd0);
        clk(1);
        chk("rot_dn_wrap", 1'b1, 1'b1, 3'd7);
        clk(1);
        chk("rot_dn_idx6", 1'b1, 1'b0, 3'd6);
        STOP = 1'b1; clk(1); STOP = 1'b0;
        chk("rot_dn_stop", 1'b0, 1'b0, 3'd6);

        // bounce up from 6, divider 2
        DIR = 1'b0; MODE = 2'b01;
        load_div(24'd2);
        START = 1'b1; clk(1); START = 1'b0;
        chk("bnc_start", 1'b1, 1'b0, 3'd6);
        clk(2);
        chk("bnc_idx7", 1'b1, 1'b0, 3'd7);
        clk(2);
        chk("bnc_turn", 1'b1, 1'b1, 3'd6);
        clk(1);
        chk("bnc_lap_off", 1'b1, 1'b0, 3'd6);
        clk(1);
        chk("bnc_idx5", 1'b1, 1'b0, 3'd5);
        STOP = 1'b1; clk(1); STOP = 1'b0;
        chk("bnc_stop", 1'b0, 1'b0, 3'd5);

        // reset asserted mid-run takes effect without a clock edge
        MODE = 2'b00;
        START = 1'b1; clk(1); START = 1'b0;
        chk("rst_run", 1'b1, 1'b0, 3'd5);
        RST = 1'b1;
        #1;
        chk("rst_async", 1'b0, 1'b0, 3'd0);
        clk(1);
        RST = 1'b0;
        clk(1);

        // single steps in IDLE
        for (int i = 1; i <= 3; i++) begin
            STEP = 1'b1; clk(1); STEP = 1'b0; clk(1);
            chk($sformatf("step%0d", i), 1'b0, 1'b0, 3'(i));
        end

        // one-lap from 3, divider 1
        MODE = 2'b10;
        load_div(24'd1);
        START = 1'b1; clk(1); START = 1'b0;
        chk("lap1_start", 1'b1, 1'b0, 3'd3);
        clk(7);
        chk("lap1_seven", 1'b1, 1'b0, 3'd2);
        clk(1);
        chk("lap1_done", 1'b0, 1'b1, 3'd3);
        clk(1);
        chk("lap1_idle", 1'b0, 1'b0, 3'd3);

        // simultaneous START and STOP stays idle
        START = 1'b1; STOP = 1'b1; clk(1); START = 1'b0; STOP = 1'b0;
        chk("start_stop", 1'b0, 1'b0, 3'd3);
        clk(2);
        chk("start_stop_hold", 1'b0, 1'b0, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
